pmipsl_mem_arbiter: RTL

Shares a single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the pipelined MIPS-Lite core. A small FSM grants one access at a time, inserts a configurable number of memory wait states and returns a one-cycle ready pulse to the winner. While either stage waits, it drives a pipeline stall that the PC and pipeline-register logic use to hold state.

---
 rtl/pmipsl_pkg.sv | 35 +++
 rtl/memarb_wait_counter.sv | 25 ++
 rtl/pmipsl_mem_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/pmipsl_pkg.sv
// Shared types and constants for the MIPS-Lite memory arbiter.
// Holds the FSM and grant encodings, bus widths and the round-robin grant helper.
package pmipsl_pkg;

    localparam int unsigned PMIPSL_AW = 16;
    localparam int unsigned PMIPSL_DW = 16;
    localparam int unsigned PMIPSL_IW = 17;
    localparam int unsigned MEMARB_CW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Latched access descriptor; address and write data sit in the mem_* registers.
    typedef struct packed {
        grant_t gnt;
        logic   we;
    } req_t;

    // When both stages are pending, the stage that did not win last time goes next.
    function automatic grant_t rr_grant(input logic if_pend, input logic d_pend,
                                        input grant_t last);
        if (if_pend && d_pend)
            return (last == GNT_I) ? GNT_D : GNT_I;
        return d_pend ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/memarb_wait_counter.sv
// Loadable 3-bit down-counter that times the wait states of one memory access.
module memarb_wait_counter
    import pmipsl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [MEMARB_CW-1:0] load_val,
    input  logic                 dec,
    output logic [MEMARB_CW-1:0] count,
    output logic                 zero_c
);

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - MEMARB_CW'(1);
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/pmipsl_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and load/store.
// Define MEMARB_RR_EN for round-robin priority; default is fixed data-over-fetch.
module pmipsl_mem_arbiter
    import pmipsl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [PMIPSL_AW-1:0] if_addr,
    output logic [PMIPSL_IW-1:0] if_rdata,
    output logic                 if_ready,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [PMIPSL_AW-1:0] d_addr,
    input  logic [PMIPSL_DW-1:0] d_wdata,
    output logic [PMIPSL_DW-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [PMIPSL_AW-1:0] mem_addr,
    output logic [PMIPSL_IW-1:0] mem_wdata,
    input  logic [PMIPSL_IW-1:0] mem_rdata,
    output logic                 stall
);

    localparam logic [MEMARB_CW-1:0] WS = MEMARB_CW'(WAIT_STATES);

    state_t               state;
    req_t                 req;
    grant_t               pick;
    logic                 d_pend;
    logic                 any_pend;
    logic [MEMARB_CW-1:0] cnt;
    logic                 cnt_zero;

    assign d_pend   = d_read | d_write;
    assign any_pend = if_req | d_pend;

`ifdef MEMARB_RR_EN
    grant_t last_gnt;
    always_comb pick = rr_grant(if_req, d_pend, last_gnt);
`else
    always_comb pick = d_pend ? GNT_D : GNT_I;
`endif

    memarb_wait_counter u_wait (
        .clock    (clock),
        .reset    (reset),
        .load     ((state == IDLE) && any_pend),
        .load_val (WS),
        .dec      (state == ACCESS),
        .count    (cnt),
        .zero_c   (cnt_zero)
    );

    // Pipeline hold while any stage has an outstanding, uncompleted request.
    assign stall = reset & ((if_req & ~if_ready) | (d_pend & ~d_ready));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            req       <= '{gnt: GNT_I, we: 1'b0};
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
`ifdef MEMARB_RR_EN
            last_gnt  <= GNT_I;
`endif
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        req.gnt   <= pick;
                        req.we    <= (pick == GNT_D) && d_write;
                        mem_en    <= 1'b1;
                        mem_addr  <= (pick == GNT_D) ? d_addr : if_addr;
                        mem_wdata <= {1'b0, d_wdata};
                        // With no wait states the single ACCESS cycle is also the strobe cycle.
                        mem_we    <= (pick == GNT_D) && d_write && (WS == '0);
`ifdef MEMARB_RR_EN
                        last_gnt  <= pick;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        mem_en <= 1'b0;
                        state  <= RESP;
                        if (req.gnt == GNT_I) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata[PMIPSL_DW-1:0];
                            d_ready <= 1'b1;
                        end
                    end else begin
                        mem_we <= req.we && (cnt == MEMARB_CW'(1));
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
